// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS32 pipeline.
// Sequences memory-wait freezes, mul/div stalls, taken-branch squashes and load-use stalls.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             muldiv_start,
  input  logic             branch_taken,
  input  logic             mem_stall_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MULDIV} state_t;

  localparam logic [7:0] LP_MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_cnt;
  logic [7:0]       w_nextCnt;
  logic [CNT_W-1:0] r_stallCount;
  logic             w_loadUse;

  assign w_loadUse = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rd)) ||
                      (id_uses_rt && (id_rt == ex_rd)));

  // Outputs are combinational from inputs and registered state so every hazard acts at the next edge.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    muldiv_done  = 1'b0;
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;

    if (rst) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_stall_req) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      // The mul/div keeps counting through a memory wait so the stall is never lengthened beyond the wait.
      if ((r_state == MULDIV) && (r_cnt != 8'd0)) begin
        w_nextCnt = r_cnt - 8'd1;
      end
    end else if (((r_state == RUN) && muldiv_start) ||
                 ((r_state == MULDIV) && (r_cnt != 8'd0))) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_flush = 1'b1;
      if (r_state == RUN) begin
        w_nextState = MULDIV;
        w_nextCnt   = LP_MD_LOAD;
      end else begin
        w_nextCnt = r_cnt - 8'd1;
      end
    end else if (r_state == MULDIV) begin
      muldiv_done = 1'b1;
      w_nextState = RUN;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end else if (w_loadUse) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_cnt        <= 8'd0;
      r_stallCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (!pc_en && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + CNT_W'(1);
      end
    end
  end

  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-counting behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] idRs = '0;
  logic [4:0] idRt = '0;
  logic [4:0] exRd = '0;
  logic       idUsesRs = 1'b0;
  logic       idUsesRt = 1'b0;
  logic       exMemRead = 1'b0;
  logic       exRegWrite = 1'b0;
  logic       muldivStart = 1'b0;
  logic       branchTaken = 1'b0;
  logic       memStallReq = 1'b0;

  logic        pcEn, ifIdEn, idExEn, exMemEn, memWbEn;
  logic        ifIdFlush, idExFlush, exMemFlush, memWbFlush, muldivDone;
  logic [31:0] stallCount;
  logic        sPcEn, sIfIdEn, sIdExEn, sExMemEn, sMemWbEn;
  logic        sIfIdFlush, sIdExFlush, sExMemFlush, sMemWbFlush, sMuldivDone;
  logic [3:0]  sStallCount;
  logic [9:0]  dutVec, satVec;

  int      checkCount = 0;
  int      passCount  = 0;
  bit      mdBusy     = 1'b0;
  int      mdElapsed  = 0;
  longint  stallTotal = 0;
  bit      doneSeen   = 1'b0;
  logic [9:0] edgeVec;

  pipe_hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt),
    .ex_mem_read(exMemRead), .ex_reg_write(exRegWrite), .ex_rd(exRd),
    .muldiv_start(muldivStart), .branch_taken(branchTaken), .mem_stall_req(memStallReq),
    .pc_en(pcEn), .if_id_en(ifIdEn), .id_ex_en(idExEn), .ex_mem_en(exMemEn), .mem_wb_en(memWbEn),
    .if_id_flush(ifIdFlush), .id_ex_flush(idExFlush), .ex_mem_flush(exMemFlush),
    .mem_wb_flush(memWbFlush), .muldiv_done(muldivDone), .stall_count(stallCount)
  );

  pipe_hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .id_rs(idRs), .id_rt(idRt),
    .id_uses_rs(idUsesRs), .id_uses_rt(idUsesRt),
    .ex_mem_read(exMemRead), .ex_reg_write(exRegWrite), .ex_rd(exRd),
    .muldiv_start(muldivStart), .branch_taken(branchTaken), .mem_stall_req(memStallReq),
    .pc_en(sPcEn), .if_id_en(sIfIdEn), .id_ex_en(sIdExEn), .ex_mem_en(sExMemEn), .mem_wb_en(sMemWbEn),
    .if_id_flush(sIfIdFlush), .id_ex_flush(sIdExFlush), .ex_mem_flush(sExMemFlush),
    .mem_wb_flush(sMemWbFlush), .muldiv_done(sMuldivDone), .stall_count(sStallCount)
  );

  assign dutVec = {pcEn, ifIdEn, idExEn, exMemEn, memWbEn,
                   ifIdFlush, idExFlush, exMemFlush, memWbFlush, muldivDone};
  assign satVec = {sPcEn, sIfIdEn, sIdExEn, sExMemEn, sMemWbEn,
                   sIfIdFlush, sIdExFlush, sExMemFlush, sMemWbFlush, sMuldivDone};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Expected control vector from the priority rules; a mul/div is tracked as cycles elapsed since its start.
  function automatic logic [9:0] modelVec();
    logic pcE, ifE, idE, exE, wbE, ifF, idF, exF, wbF, dn, ldUse;
    pcE = 1; ifE = 1; idE = 1; exE = 1; wbE = 1;
    ifF = 0; idF = 0; exF = 0; wbF = 0; dn = 0;
    ldUse = exMemRead && exRegWrite && (exRd != 0) &&
            ((idUsesRs && idRs == exRd) || (idUsesRt && idRt == exRd));
    if (rst) begin
      pcE = 0; ifE = 0; idE = 0; exE = 0; wbE = 0;
    end else if (memStallReq) begin
      pcE = 0; ifE = 0; idE = 0; exE = 0; wbF = 1;
    end else if ((!mdBusy && muldivStart) || (mdBusy && mdElapsed < N)) begin
      pcE = 0; ifE = 0; idE = 0; exF = 1;
    end else if (mdBusy) begin
      dn = 1;
    end else if (branchTaken) begin
      ifF = 1;
    end else if (ldUse) begin
      pcE = 0; ifE = 0; idF = 1;
    end
    return {pcE, ifE, idE, exE, wbE, ifF, idF, exF, wbF, dn};
  endfunction

  // Advance the model at each edge using the inputs of the cycle that just ended.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdBusy = 0; mdElapsed = 0; stallTotal = 0;
    end else begin
      edgeVec = modelVec();
      if (!edgeVec[9]) stallTotal++;
      if (!mdBusy) begin
        if (!memStallReq && muldivStart) begin
          mdBusy = 1; mdElapsed = 1;
        end
      end else if (!memStallReq && mdElapsed >= N) begin
        mdBusy = 0;
      end else begin
        mdElapsed++;
      end
    end
  end

  // Mid-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("ctrl", dutVec, modelVec());
    checkOutput("ctrlSat", satVec, modelVec());
    checkOutput("stallCount", stallCount, (stallTotal > 64'd4294967295) ? 64'd4294967295 : stallTotal);
    checkOutput("stallCountSat", sStallCount, (stallTotal > 15) ? 15 : stallTotal);
    if (muldivDone) doneSeen = 1;
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic usesRs, input logic usesRt, input logic memRead,
                               input logic regWrite, input logic start, input logic taken,
                               input logic memReq);
    idRs = rs; idRt = rt; exRd = rd; idUsesRs = usesRs; idUsesRt = usesRt;
    exMemRead = memRead; exRegWrite = regWrite; muldivStart = start;
    branchTaken = taken; memStallReq = memReq;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic resetDut();
    @(posedge clk);
    #3 rst = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst = 0;
  endtask

  initial begin
    #12 rst = 0;
    checkOutput("resetCount", stallCount, 0);

    resetDut();
    applyStimulus(5, 0, 5, 1, 0, 1, 1, 0, 0, 0);
    #1;
    checkOutput("ldUsePcEn", pcEn, 0);
    checkOutput("ldUseIfIdEn", ifIdEn, 0);
    checkOutput("ldUseIdExFlush", idExFlush, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ldUseCleared", pcEn, 1);
    checkOutput("ldUseCount", stallCount, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    #1;
    checkOutput("ldUseRdZero", pcEn, 1);
    stepCycle();
    checkOutput("ldUseRdZeroCount", stallCount, 1);

    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    checkOutput("mdC0PcEn", pcEn, 0);
    checkOutput("mdC0ExMemFlush", exMemFlush, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < N; k++) begin
      #1;
      checkOutput("mdStallPcEn", pcEn, 0);
      checkOutput("mdStallFlush", exMemFlush, 1);
      checkOutput("mdStallNoDone", muldivDone, 0);
      stepCycle();
    end
    #1;
    checkOutput("mdReleaseDone", muldivDone, 1);
    checkOutput("mdReleasePcEn", pcEn, 1);
    checkOutput("mdCount", stallCount, 4);
    stepCycle();
    checkOutput("mdDoneOnePulse", muldivDone, 0);

    resetDut();
    applyStimulus(5, 0, 5, 1, 0, 1, 1, 0, 1, 0);
    #1;
    checkOutput("brIfIdFlush", ifIdFlush, 1);
    checkOutput("brPcEn", pcEn, 1);
    checkOutput("brIdExFlush", idExFlush, 0);

    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    stepCycle();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      checkOutput("mwFlush", memWbFlush, 1);
      checkOutput("mwNoDone", muldivDone, 0);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("mwReleaseC7", muldivDone, 1);
    checkOutput("mwCount", stallCount, 7);

    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    doneSeen = 0;
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    #1 rst = 1;
    #1;
    checkOutput("rstPcEn", pcEn, 0);
    checkOutput("rstMemWbEn", memWbEn, 0);
    checkOutput("rstExMemFlush", exMemFlush, 0);
    stepCycle();
    stepCycle();
    #1 rst = 0;
    #1;
    checkOutput("rstRunPcEn", pcEn, 1);
    for (int k = 0; k < 6; k++) stepCycle();
    checkOutput("rstCount", stallCount, 0);
    checkOutput("rstNoDone", doneSeen, 0);

    resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) stepCycle();
    #1;
    checkOutput("satCount", sStallCount, 15);
    checkOutput("wideCount", stallCount, 20);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 800; k++) begin
      stepCycle();
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 6) == 0));
    end
    stepCycle();
    rst = 0;
    stepCycle();

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
